alu_sched: RTL and testbench
============================

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits.
REQ-002 The block SHALL have parameter SEL_W, default 4, meaning the ALU operation-select width in bits.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-005 The block SHALL have ports req0 and req1, input, 1 each, the operation request from requester 0 and requester 1.
REQ-006 The block SHALL have ports a0, b0, a1 and b1, input, WIDTH each, the per-requester operands.
REQ-007 The block SHALL have ports s0 and s1, input, SEL_W each, the per-requester operation select.
REQ-008 The block SHALL have ports cin0 and cin1, input, 1 each, the per-requester carry-in.
REQ-009 The block SHALL have port gnt, output, 2, the one-hot grant pulse; bit i corresponds to requester i.
REQ-010 The block SHALL have ports alu_a and alu_b (output, WIDTH), alu_s (output, SEL_W) and alu_cin (output, 1), the registered drive to the shared ALU.
REQ-011 The block SHALL have ports alu_d (input, WIDTH), alu_cout (input, 1) and alu_z (input, 1), the combinational results returned by the shared ALU.
REQ-012 The block SHALL have ports res_d (output, WIDTH), res_cout (output, 1), res_z (output, 1) and res_id (output, 1), the captured result and the id of the requester that owns it.
REQ-013 The block SHALL have ports done (output, 2), the one-hot completion pulse, and busy (output, 1), high while an operation occupies the ALU.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and EXEC.
REQ-015 In IDLE with at least one req high, the block SHALL, at the clock edge, select a winner, load that requester's a, b, s and cin into alu_a, alu_b, alu_s and alu_cin, set gnt[winner], and enter EXEC.
REQ-016 In IDLE with no req high, the block SHALL remain in IDLE with gnt at 0 and the alu_* registers holding their values.
REQ-017 In EXEC, the block SHALL hold busy at 1 and gnt one-hot for exactly one cycle, and SHALL keep alu_* stable.
REQ-018 At the end of EXEC, the block SHALL capture alu_d, alu_cout and alu_z into res_d, res_cout and res_z, set res_id to the winner and done[winner] to 1, and return to IDLE.
REQ-019 Latency SHALL be as follows: req sampled at edge N gives gnt and alu_* valid in cycle N+1, and done and res_* valid in cycle N+2.
REQ-020 Throughput SHALL be one operation per 2 cycles; a request present in the done cycle SHALL be accepted at that edge.
REQ-021 done SHALL be a one-cycle pulse; res_* SHALL hold until the next capture.
REQ-022 Requesters SHALL hold req and operands until gnt[i] is seen; a req still high after its done SHALL be treated as a new request.
REQ-023 Arbitration SHALL be round-robin via a last-served pointer: when both requests are high, the requester not served last wins; a single request always wins.
REQ-024 req inputs that are high during EXEC SHALL be ignored until the FSM returns to IDLE; requests SHALL NOT be queued.
REQ-025 At most one gnt bit and at most one done bit SHALL be high in any cycle.

Reset
REQ-026 While rst is high, the block SHALL set the state to IDLE, and gnt, done, busy, alu_a, alu_b, alu_s, alu_cin, res_d, res_cout, res_z and res_id to 0, and the last-served pointer to 1 so that requester 0 wins the first tie.
REQ-027 rst asserted during EXEC SHALL abort the operation: no done pulse and no res_* update.
REQ-028 rst SHALL take priority over all requests in the same cycle.

Configuration
REQ-029 With macro ALU_SCHED_FIXED_PRIO_EN defined, requester 0 SHALL always win a tie and the last-served pointer SHALL be omitted.
REQ-030 Without ALU_SCHED_FIXED_PRIO_EN, arbitration SHALL be round-robin as specified in REQ-023; all other behaviour SHALL be identical in both builds.

Verification
REQ-031 Single request: req0=1, a0=81, b0=80, s0=0000, cin0=1, with the ALU stub returning alu_d=8'hA2 -> gnt=01 and alu_a=81, alu_b=80, alu_s=0000, alu_cin=1 at N+1; done=01, res_d=A2 and res_id=0 at N+2.
REQ-032 Tie after reset: req0=req1=1 held -> grants alternate 01, 10, 01, 10 at cycles N+1, N+3, N+5, N+7 (round-robin build).
REQ-033 Fixed-priority build, same stimulus as REQ-032 -> every grant is 01 and requester 1 is never granted while req0 is high.
REQ-034 Back-to-back: req1 held with s1 changed 0000->0100 after the first gnt -> the second gnt arrives in the cycle after the first done, and alu_s=0100.
REQ-035 Reset mid-EXEC: rst=1 in cycle N+1 -> no done pulse; all outputs are 0 at N+2; a subsequent req0 is served normally.
REQ-036 Flag capture: stub alu_d=0, alu_z=1, alu_cout=1 -> res_z=1 and res_cout=1 with the done pulse, and both hold after done falls.

Source files
------------

// File: rtl/alu_sched.sv
// Two-requester scheduler for one shared ALU: arbitrate, register operands, capture result.
// Build option ALU_SCHED_FIXED_PRIO_EN: requester 0 always wins a tie (no last-served pointer).
module alu_sched #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [SEL_W-1:0] s0,
    input  logic [SEL_W-1:0] s1,
    input  logic             cin0,
    input  logic             cin1,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_s,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_d,
    input  logic             alu_cout,
    input  logic             alu_z,
    output logic [WIDTH-1:0] res_d,
    output logic             res_cout,
    output logic             res_z,
    output logic             res_id,
    output logic [1:0]       done,
    output logic             busy
);
    // state | meaning
    // IDLE  | no operation in flight; done pulses here; a request is accepted at the edge
    // EXEC  | operands held on the ALU; result captured at the end of this cycle
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0] alu_s_q, alu_s_d;
    logic             alu_cin_q, alu_cin_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_cout_q, res_cout_d;
    logic             res_z_q, res_z_d;
    logic             res_id_q, res_id_d;
    logic             winner;

`ifdef ALU_SCHED_FIXED_PRIO_EN
    assign winner = ~req0;
`else
    logic last_q, last_d;
    // On a tie the requester not served last wins
    assign winner = (req0 & req1) ? ~last_q : req1;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_s_d    = alu_s_q;
        alu_cin_d  = alu_cin_q;
        res_data_d = res_data_q;
        res_cout_d = res_cout_q;
        res_z_d    = res_z_q;
        res_id_d   = res_id_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        if (state_q == IDLE) begin
            if (req0 | req1) begin
                state_d   = EXEC;
                gnt_d     = winner ? 2'b10 : 2'b01;
                alu_a_d   = winner ? a1 : a0;
                alu_b_d   = winner ? b1 : b0;
                alu_s_d   = winner ? s1 : s0;
                alu_cin_d = winner ? cin1 : cin0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
                last_d    = winner;
`endif
            end
        end else begin
            // gnt_q still identifies the owner during EXEC
            state_d    = IDLE;
            done_d     = gnt_q;
            res_data_d = alu_d;
            res_cout_d = alu_cout;
            res_z_d    = alu_z;
            res_id_d   = gnt_q[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_s_q    <= '0;
            alu_cin_q  <= 1'b0;
            res_data_q <= '0;
            res_cout_q <= 1'b0;
            res_z_q    <= 1'b0;
            res_id_q   <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_s_q    <= alu_s_d;
            alu_cin_q  <= alu_cin_d;
            res_data_q <= res_data_d;
            res_cout_q <= res_cout_d;
            res_z_q    <= res_z_d;
            res_id_q   <= res_id_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign busy     = (state_q == EXEC);
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_s    = alu_s_q;
    assign alu_cin  = alu_cin_q;
    assign res_d    = res_data_q;
    assign res_cout = res_cout_q;
    assign res_z    = res_z_q;
    assign res_id   = res_id_q;

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: transaction-level model checked every cycle plus directed literal checks.
module tb_alu_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, cin0, cin1;
    logic [7:0] a0, b0, a1, b1;
    logic [3:0] s0, s1;
    logic [1:0] gnt, done;
    logic [7:0] alu_a, alu_b, alu_d, res_d;
    logic [3:0] alu_s;
    logic       alu_cin, alu_cout, alu_z, res_cout, res_z, res_id, busy;

    // ALU stub: results are whatever the bench chooses
    logic [7:0] stub_d;
    logic       stub_c, stub_z;
    assign alu_d    = stub_d;
    assign alu_cout = stub_c;
    assign alu_z    = stub_z;

    alu_sched #(.WIDTH(8), .SEL_W(4)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .s0(s0), .s1(s1),
        .cin0(cin0), .cin1(cin1), .gnt(gnt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
        .alu_d(alu_d), .alu_cout(alu_cout), .alu_z(alu_z),
        .res_d(res_d), .res_cout(res_cout), .res_z(res_z), .res_id(res_id),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an operation is either absent, in flight (one cycle), or just completed
    bit         in_flight;
    bit         owner;
    bit         last_served;
    logic [1:0] e_gnt, e_done;
    logic       e_busy, e_cin, e_cout, e_z, e_id;
    logic [7:0] e_a, e_b, e_res;
    logic [3:0] e_s;

    always @(posedge clk) begin
        if (rst) begin
            in_flight = 0; last_served = 1;
            e_gnt = 0; e_done = 0; e_busy = 0;
            e_a = 0; e_b = 0; e_s = 0; e_cin = 0;
            e_res = 0; e_cout = 0; e_z = 0; e_id = 0;
        end else if (in_flight) begin
            in_flight = 0;
            e_gnt = 0; e_busy = 0;
            e_done = (owner ? 2'b10 : 2'b01);
            e_res = stub_d; e_cout = stub_c; e_z = stub_z; e_id = owner;
        end else begin
            e_done = 0;
            if (req0 || req1) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
                owner = !req0;
`else
                if (req0 && req1) owner = !last_served;
                else owner = req1;
`endif
                last_served = owner;
                in_flight = 1;
                e_gnt = (owner ? 2'b10 : 2'b01);
                e_busy = 1;
                e_a = owner ? a1 : a0;
                e_b = owner ? b1 : b0;
                e_s = owner ? s1 : s0;
                e_cin = owner ? cin1 : cin0;
            end else begin
                e_gnt = 0; e_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt", gnt, e_gnt);
            chk("done", done, e_done);
            chk("busy", busy, e_busy);
            chk("alu_a", alu_a, e_a);
            chk("alu_b", alu_b, e_b);
            chk("alu_s", alu_s, e_s);
            chk("alu_cin", alu_cin, e_cin);
            chk("res_d", res_d, e_res);
            chk("res_cout", res_cout, e_cout);
            chk("res_z", res_z, e_z);
            chk("res_id", res_id, e_id);
            if ($countones(gnt) > 1) chk("gnt_onehot", gnt, e_gnt);
            if ($countones(done) > 1) chk("done_onehot", done, e_done);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_g;
        rst = 1; req0 = 0; req1 = 0; cin0 = 0; cin1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0; s0 = 0; s1 = 0;
        stub_d = 8'h00; stub_c = 0; stub_z = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1;
        #1 rst = 0;

        // Reset values, then single request on requester 0
        @(negedge clk);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_res_d", res_d, 8'h00);
        #1 req0 = 1; a0 = 8'h81; b0 = 8'h80; s0 = 4'b0000; cin0 = 1; stub_d = 8'hA2;
        @(negedge clk);
        chk("single_gnt", gnt, 2'b01);
        chk("single_alu_a", alu_a, 8'h81);
        chk("single_alu_b", alu_b, 8'h80);
        chk("single_alu_s", alu_s, 4'b0000);
        chk("single_alu_cin", alu_cin, 1'b1);
        chk("single_busy", busy, 1'b1);
        #1 req0 = 0;
        @(negedge clk);
        chk("single_done", done, 2'b01);
        chk("single_res_d", res_d, 8'hA2);
        chk("single_res_id", res_id, 1'b0);

        // Tie after reset: alternating grants (fixed-priority build: always 01)
        #1 rst = 1;
        @(negedge clk);
        #1 rst = 0; req0 = 1; req1 = 1; a1 = 8'h0F; b1 = 8'hF0; s1 = 4'b0010; stub_d = 8'h3C;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
`ifdef ALU_SCHED_FIXED_PRIO_EN
            exp_g = (k % 2) ? 2'b00 : 2'b01;
`else
            exp_g = (k % 2) ? 2'b00 : (((k / 2) % 2) ? 2'b10 : 2'b01);
`endif
            chk("tie_gnt", gnt, exp_g);
        end

        // Back-to-back on requester 1 with a select change after the first grant
        #1 req0 = 0; req1 = 1; a1 = 8'h05; b1 = 8'h03; s1 = 4'b0000; cin1 = 0; stub_d = 8'h08;
        @(negedge clk);
        chk("b2b_gnt1", gnt, 2'b10);
        chk("b2b_s1", alu_s, 4'b0000);
        #1 s1 = 4'b0100;
        @(negedge clk);
        chk("b2b_done1", done, 2'b10);
        chk("b2b_res_id", res_id, 1'b1);
        @(negedge clk);
        chk("b2b_gnt2", gnt, 2'b10);
        chk("b2b_s2", alu_s, 4'b0100);
        #1 req1 = 0;
        @(negedge clk);
        chk("b2b_done2", done, 2'b10);

        // Reset mid-EXEC aborts; next request served normally
        #1 req0 = 1; a0 = 8'h11; b0 = 8'h22; s0 = 4'b0001; cin0 = 1; stub_d = 8'h55;
        @(negedge clk);
        chk("abort_gnt", gnt, 2'b01);
        #1 rst = 1; req0 = 0;
        @(negedge clk);
        chk("abort_done", done, 2'b00);
        chk("abort_gnt0", gnt, 2'b00);
        chk("abort_alu_a", alu_a, 8'h00);
        chk("abort_res_d", res_d, 8'h00);
        chk("abort_busy", busy, 1'b0);
        #1 rst = 0; req0 = 1; a0 = 8'h22;
        @(negedge clk);
        chk("after_gnt", gnt, 2'b01);
        chk("after_alu_a", alu_a, 8'h22);
        #1 req0 = 0;
        @(negedge clk);
        chk("after_done", done, 2'b01);
        chk("after_res_d", res_d, 8'h55);

        // Flag capture and hold
        #1 req0 = 1; stub_d = 8'h00; stub_z = 1; stub_c = 1;
        @(negedge clk);
        #1 req0 = 0;
        @(negedge clk);
        chk("flag_done", done, 2'b01);
        chk("flag_z", res_z, 1'b1);
        chk("flag_cout", res_cout, 1'b1);
        #1 stub_z = 0; stub_c = 0;
        @(negedge clk);
        chk("flag_done_low", done, 2'b00);
        chk("flag_z_hold", res_z, 1'b1);
        chk("flag_cout_hold", res_cout, 1'b1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
